ps2_key_receiver: RTL and testbench

Upstream keyboard front end for the MiniAlu key-input path. Receives PS/2 device-to-host frames on `PS2_CLK`/`PS2_DATA`, filters and synchronises both lines into the `Clock` domain, and validates each frame: start bit, 8 data bits LSB-first, odd parity and stop bit. Valid scan-code bytes go into a small FIFO, which the ALU consumes one byte per `iPop`. It replaces the ad-hoc filter and `serial2parallel` pairing with a single-clock, glitch-tolerant receiver that has a handshake interface.

---
 rtl/ps2_pkg.sv | 20 ++
 rtl/ps2_line_filter.sv | 52 +++++
 rtl/ps2_key_receiver.sv | 177 +++++++++++++++++
 tb/tb_ps2_key_receiver.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 key receiver: frame FSM encoding, scan-code
// constants and the odd-parity check.
package ps2_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } ps2_state_e;

  localparam logic [7:0] PS2_BREAK = 8'hF0;
  localparam logic [7:0] PS2_EXT   = 8'hE0;

  // A frame is good when the data byte plus its parity bit has an odd number of ones.
  function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
    return ^{data, par};
  endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// Two-flop synchroniser plus saturating glitch filter for one PS/2 line.
// Emits the filtered level and a one-cycle strobe when that level falls.
module ps2_line_filter #(
  parameter int FILTER_LEN = 8
) (
  input  logic clk,
  input  logic srst,
  input  logic pin_i,
  output logic level_o,
  output logic fall_o
);

  localparam int CW = $clog2(FILTER_LEN + 1);

  logic [1:0]    sync_q;
  logic          level_q, level_d;
  logic          fall_q, fall_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Any sample that agrees with the current level restarts the run count.
  always_comb begin
    level_d = level_q;
    fall_d  = 1'b0;
    cnt_d   = '0;
    if (sync_q[1] != level_q) begin
      if (cnt_q == CW'(FILTER_LEN - 1)) begin
        level_d = sync_q[1];
        fall_d  = ~sync_q[1];
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      sync_q  <= 2'b11;
      level_q <= 1'b1;
      fall_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync_q  <= {sync_q[0], pin_i};
      level_q <= level_d;
      fall_q  <= fall_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level_o = level_q;
  assign fall_o  = fall_q;

endmodule

// File: rtl/ps2_key_receiver.sv
// PS/2 device-to-host frame receiver with scan-code FIFO and pop handshake.
// Define PS2_BREAK_FILTER_EN to drop break codes (F0 and the byte after it).
module ps2_key_receiver
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN  = 8,
  parameter int FIFO_DEPTH  = 4,
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       PS2_CLK,
  input  logic       PS2_DATA,
  input  logic       iPop,
  output logic [7:0] oKey,
  output logic       oKeyValid,
  output logic       oFrameError,
  output logic       oOverflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  // Line 0 is the PS/2 clock, line 1 the PS/2 data.
  logic [1:0] pin_raw, line_lvl, line_fall;
  logic       clk_fall, data_lvl, filt_unused;

  assign pin_raw = {PS2_DATA, PS2_CLK};

  for (genvar gi = 0; gi < 2; gi++) begin : g_line
    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_filter (
      .clk    (Clock),
      .srst   (Reset),
      .pin_i  (pin_raw[gi]),
      .level_o(line_lvl[gi]),
      .fall_o (line_fall[gi])
    );
  end

  assign clk_fall    = line_fall[0];
  assign data_lvl    = line_lvl[1];
  assign filt_unused = line_fall[1] ^ line_lvl[0];

  ps2_state_e    state_q, state_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    shift_q, shift_d;
  logic          parity_q, parity_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          err_q, err_d;
  logic          push_req;
`ifdef PS2_BREAK_FILTER_EN
  logic          skip_q, skip_d;
`endif

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    parity_d  = parity_q;
    tmo_d     = '0;
    err_d     = 1'b0;
    push_req  = 1'b0;
`ifdef PS2_BREAK_FILTER_EN
    skip_d    = skip_q;
`endif
    case (state_q)
      IDLE: if (clk_fall) begin
        if (!data_lvl) begin
          state_d   = DATA;
          bit_cnt_d = '0;
        end else begin
          err_d = 1'b1;
        end
      end
      DATA: if (clk_fall) begin
        shift_d   = {data_lvl, shift_q[7:1]};
        bit_cnt_d = bit_cnt_q + 1'b1;
        if (bit_cnt_q == 3'd7) state_d = PARITY;
      end
      PARITY: if (clk_fall) begin
        parity_d = data_lvl;
        state_d  = STOP;
      end
      STOP: if (clk_fall) begin
        state_d = IDLE;
        if (data_lvl && odd_parity_ok(shift_q, parity_q)) begin
`ifdef PS2_BREAK_FILTER_EN
          if (shift_q == PS2_EXT)        push_req = 1'b1;
          else if (skip_q)               skip_d   = 1'b0;
          else if (shift_q == PS2_BREAK) skip_d   = 1'b1;
          else                           push_req = 1'b1;
`else
          push_req = 1'b1;
`endif
        end else begin
          err_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Inter-edge watchdog: a stalled frame is abandoned and reported.
    if (state_q != IDLE && !clk_fall) begin
      if (tmo_q == TW'(TIMEOUT_CYC - 1)) begin
        state_d = IDLE;
        shift_d = '0;
        err_d   = 1'b1;
      end else begin
        tmo_d = tmo_q + 1'b1;
      end
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      parity_q  <= 1'b0;
      tmo_q     <= '0;
      err_q     <= 1'b0;
`ifdef PS2_BREAK_FILTER_EN
      skip_q    <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      parity_q  <= parity_d;
      tmo_q     <= tmo_d;
      err_q     <= err_d;
`ifdef PS2_BREAK_FILTER_EN
      skip_q    <= skip_d;
`endif
    end
  end

  logic [7:0]  mem_q [FIFO_DEPTH];
  logic [AW:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic        ovf_q, ovf_d;
  logic        empty, full, do_push, do_pop;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_pop  = iPop && !empty;
  assign do_push = push_req && (!full || do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, do_push};
    rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, do_pop};
    ovf_d    = ovf_q | (push_req && full && !do_pop);
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      ovf_q    <= ovf_d;
    end
  end

  always_ff @(posedge Clock) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= shift_q;
  end

  assign oKey        = empty ? 8'h00 : mem_q[rd_ptr_q[AW-1:0]];
  assign oKeyValid   = !empty;
  assign oFrameError = err_q;
  assign oOverflow   = ovf_q;

endmodule

// File: tb/tb_ps2_key_receiver.sv
// Directed-vector bench for ps2_key_receiver: a scoreboard queue holds expected
// scan codes and a monitor process pops and compares whenever a key is offered.
module tb_ps2_key_receiver;

  localparam int FILTER_LEN  = 8;
  localparam int FIFO_DEPTH  = 4;
  localparam int TIMEOUT_CYC = 300;
  localparam int HALF        = 20;

  logic       clk = 1'b0;
  logic       Reset, PS2_CLK, PS2_DATA, iPop;
  logic [7:0] oKey;
  logic       oKeyValid, oFrameError, oOverflow;

  always #5 clk = ~clk;

  ps2_key_receiver #(
    .FILTER_LEN (FILTER_LEN),
    .FIFO_DEPTH (FIFO_DEPTH),
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .Clock      (clk),
    .Reset      (Reset),
    .PS2_CLK    (PS2_CLK),
    .PS2_DATA   (PS2_DATA),
    .iPop       (iPop),
    .oKey       (oKey),
    .oKeyValid  (oKeyValid),
    .oFrameError(oFrameError),
    .oOverflow  (oOverflow)
  );

  int         n_checks = 0;
  int         n_fail   = 0;
  int         err_cnt  = 0;
  int         exp_err  = 0;
  logic [7:0] exp_q[$];
  bit         auto_pop  = 1'b0;
  bit         force_pop = 1'b0;

  // Monitor: samples on the falling clock edge, owns iPop.
  initial begin
    logic [7:0] exp_b;
    iPop = 1'b0;
    forever begin
      @(negedge clk);
      if (Reset) begin
        iPop = 1'b0;
      end else begin
        if (oFrameError) err_cnt++;
        if (force_pop || (auto_pop && oKeyValid)) begin
          if (oKeyValid) begin
            n_checks++;
            if (exp_q.size() == 0) begin
              n_fail++;
              $display("FAIL scoreboard: got key %02h, expected no key", oKey);
            end else begin
              exp_b = exp_q.pop_front();
              if (oKey !== exp_b) begin
                n_fail++;
                $display("FAIL scoreboard: got key %02h, expected %02h", oKey, exp_b);
              end else begin
                $display("pop key %02h ok", oKey);
              end
            end
          end
          iPop      = 1'b1;
          force_pop = 1'b0;
        end else begin
          iPop = 1'b0;
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end else begin
      $display("check %s = %0h ok", name, act);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  function automatic logic [10:0] frame_bits(input logic [7:0] b, input logic bad_par);
    return {1'b1, (~^b) ^ bad_par, b, 1'b0};
  endfunction

  // mode 1: check push latency at the stop bit; mode 2: pop on the push cycle.
  task automatic send_bits(input logic [10:0] bits, input int n, input int mode);
    for (int i = 0; i < n; i++) begin
      PS2_DATA = bits[i];
      wait_cyc(HALF / 2);
      PS2_CLK = 1'b0;
      if (i == 10 && mode == 1) begin
        wait_cyc(FILTER_LEN + 2);
        check("pre_push_valid", 32'(oKeyValid), 32'd0);
        wait_cyc(1);
        check("push_valid", 32'(oKeyValid), 32'd1);
        check("push_key", 32'(oKey), 32'(bits[8:1]));
        wait_cyc(HALF - FILTER_LEN - 3);
      end else if (i == 10 && mode == 2) begin
        wait_cyc(FILTER_LEN + 2);
        force_pop = 1'b1;
        wait_cyc(HALF - FILTER_LEN - 2);
      end else begin
        wait_cyc(HALF);
      end
      PS2_CLK = 1'b1;
      wait_cyc(HALF / 2);
    end
    PS2_DATA = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic bad_par, input int mode);
    send_bits(frame_bits(b, bad_par), 11, mode);
    wait_cyc(5);
  endtask

  task automatic drain;
    for (int i = 0; i < 500 && exp_q.size() != 0; i++) wait_cyc(1);
    wait_cyc(3);
    check("drain_left", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    n_fail++;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    Reset    = 1'b1;
    PS2_CLK  = 1'b1;
    PS2_DATA = 1'b1;
    wait_cyc(5);
    Reset = 1'b0;
    wait_cyc(2);
    check("rst_key", 32'(oKey), 32'h00);
    check("rst_valid", 32'(oKeyValid), 32'd0);
    check("rst_err", 32'(oFrameError), 32'd0);
    check("rst_ovf", 32'(oOverflow), 32'd0);

    // Valid 1C with push-latency check, then pop.
    exp_q.push_back(8'h1C);
    send_frame(8'h1C, 1'b0, 1);
    auto_pop = 1'b1;
    wait_cyc(5);
    check("after_pop_valid", 32'(oKeyValid), 32'd0);
    check("after_pop_key", 32'(oKey), 32'h00);

    // Parity error.
    send_frame(8'h1C, 1'b1, 0);
    exp_err++;
    check("parity_err_cnt", 32'(err_cnt), 32'(exp_err));
    check("parity_valid", 32'(oKeyValid), 32'd0);

    // Glitch one cycle shorter than the filter.
    PS2_CLK = 1'b0;
    wait_cyc(FILTER_LEN - 1);
    PS2_CLK = 1'b1;
    wait_cyc(40);
    check("glitch_err_cnt", 32'(err_cnt), 32'(exp_err));

    // Lone falling edge with data high is a bad start bit.
    send_bits(11'h7FF, 1, 0);
    wait_cyc(5);
    exp_err++;
    check("start_err_cnt", 32'(err_cnt), 32'(exp_err));

    // Frame abandoned after 4 data bits, then a good 29.
    send_bits(frame_bits(8'h29, 1'b0), 5, 0);
    wait_cyc(TIMEOUT_CYC + 20);
    exp_err++;
    check("timeout_err_cnt", 32'(err_cnt), 32'(exp_err));
    exp_q.push_back(8'h29);
    send_frame(8'h29, 1'b0, 0);
    drain();

    // Pop while empty must be ignored.
    force_pop = 1'b1;
    wait_cyc(3);
    check("empty_pop_valid", 32'(oKeyValid), 32'd0);
    check("empty_pop_key", 32'(oKey), 32'h00);

    // Fill, overflow, then push and pop together while full.
    auto_pop = 1'b0;
    exp_q.push_back(8'h01);
    exp_q.push_back(8'h02);
    exp_q.push_back(8'h03);
    exp_q.push_back(8'h04);
    exp_q.push_back(8'h06);
    for (int k = 1; k <= 4; k++) send_frame(8'(k), 1'b0, 0);
    check("full_ovf", 32'(oOverflow), 32'd0);
    check("full_valid", 32'(oKeyValid), 32'd1);
    send_frame(8'h05, 1'b0, 0);
    check("drop_ovf", 32'(oOverflow), 32'd1);
    check("drop_head", 32'(oKey), 32'h01);
    send_frame(8'h06, 1'b0, 2);
    check("pushpop_head", 32'(oKey), 32'h02);
    check("pushpop_ovf", 32'(oOverflow), 32'd1);
    auto_pop = 1'b1;
    drain();
    check("drained_valid", 32'(oKeyValid), 32'd0);

    // Reset in the middle of a frame.
    send_bits(frame_bits(8'h5A, 1'b0), 4, 0);
    Reset = 1'b1;
    wait_cyc(3);
    Reset = 1'b0;
    wait_cyc(1);
    check("midrst_ovf", 32'(oOverflow), 32'd0);
    check("midrst_valid", 32'(oKeyValid), 32'd0);
    check("midrst_err", 32'(oFrameError), 32'd0);
    wait_cyc(TIMEOUT_CYC + 50);
    check("midrst_err_cnt", 32'(err_cnt), 32'(exp_err));
    exp_q.push_back(8'h5A);
    send_frame(8'h5A, 1'b0, 0);
    drain();

    // Break-code sequence.
`ifdef PS2_BREAK_FILTER_EN
    exp_q.push_back(8'h1C);
`else
    exp_q.push_back(8'h1C);
    exp_q.push_back(8'hF0);
    exp_q.push_back(8'h1C);
`endif
    send_frame(8'h1C, 1'b0, 0);
    send_frame(8'hF0, 1'b0, 0);
    send_frame(8'h1C, 1'b0, 0);
    drain();
    check("final_valid", 32'(oKeyValid), 32'd0);
    check("final_err_cnt", 32'(err_cnt), 32'(exp_err));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
